// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared types and constants for the down-counting timer
`timescale 1ns/1ps
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counting timer with CTRL/PRESET/COUNT registers
// and a registered, maskable interrupt request.
`timescale 1ns/1ps
module timer_counter
  import tc_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  tc_state_e         state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              irq_q, irq_d;

  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       hw_en_clr;
  logic [1:0] mode;
  logic       unused_addr_bits;

  assign sel              = addr[3:2];
  assign wr_ctrl          = we && (sel == OFF_CTRL);
  assign wr_preset        = we && (sel == OFF_PRESET);
  assign mode             = ctrl_q[MODE_LSB+1:MODE_LSB];
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    hw_en_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[EN_BIT]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[EN_BIT]) begin
          state_d = IDLE;
        end else if (count_q > DATA_W'(1)) begin
          count_d = count_q - DATA_W'(1);
        end else begin
          // Zero preset lands here too, so the count never underflows.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hw_en_clr) ctrl_d[EN_BIT] = 1'b0;

    // A software CTRL write overrides the hardware EN clear and always drops the flag.
    if (wr_ctrl) begin
      ctrl_d     = din[3:0];
      irq_flag_d = 1'b0;
    end

    if (wr_preset) preset_d = din;

    irq_d = irq_flag_d & ctrl_d[IM_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= PRESET_RST;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      OFF_CTRL:   dout = {{(DATA_W-4){1'b0}}, ctrl_q};
      OFF_PRESET: dout = preset_q;
      OFF_COUNT:  dout = count_q;
      default:    dout = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped down-counting timer; one instance per timer window (TC0 at 0x7F00–0x7F0B, TC1 at 0x7F10–0x7F1B).
- Sits directly downstream of the system bridge: consumes the decoded write-enable, the address and the CPU store data; returns read data to the bridge's read mux.
- Raises an interrupt request to the CP0 hardware-interrupt input when the count expires.
- Three word registers, selected by addr[3:2]:
  - CTRL at +0x0
  - PRESET at +0x4
  - COUNT at +0x8 (read-only)

Parameters:
DATA_W, 32, register/data width (fixed at 32; parameterised for lint only)
PRESET_RST, 32'h0000_0000, PRESET value after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  full bus address; only addr[3:2] decoded
we  input  1  write strobe, already qualified by window hit and nonzero byteen
din  input  32  write data
dout  output  32  read data, combinational from addr[3:2]
irq  output  1  interrupt request, registered

Behaviour:

CTRL register:
- Bits [3:0] are storage; bits [31:4] read 0 and ignore writes.
- [0] EN: enable.
- [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
- [3] IM: interrupt mask, 1 = irq allowed.

Register access:
- PRESET: full 32-bit read/write.
- COUNT: read-only; writes ignored.
- Offset 0xC: reads 0, writes ignored.
- dout: {28'b0,CTRL}, PRESET, COUNT, or 0 per addr[3:2]. Zero-latency combinational read.

Reset:
- CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0, irq=0.
- Asserting rst_n mid-count aborts immediately and clears irq.

FSM states: IDLE, LOAD, CNT, INT.
- IDLE: EN=1 -> LOAD; else stay. COUNT holds.
- LOAD: COUNT<=PRESET; -> CNT.
- CNT:
  - EN=0 -> IDLE, COUNT frozen.
  - Else if COUNT>1: COUNT<=COUNT-1.
  - Else (COUNT is 0 or 1): COUNT<=0, irq_flag<=1, -> INT.
- INT:
  - Mode one-shot: hardware clears CTRL.EN; -> IDLE; irq_flag stays 1 until any CTRL write.
  - Mode auto-reload: -> LOAD; irq_flag cleared on leaving INT, giving a one-cycle pulse.

Output:
- irq = irq_flag & CTRL.IM, registered (updated on the same edge as irq_flag).

Latency:
- CTRL write with EN=1 sampled at edge E0.
- LOAD entered at E1; COUNT=PRESET at E2.
- irq rises after edge E0+N+2 for PRESET=N>=1.
- PRESET=0 behaves as PRESET=1 (irq after E0+3).

Boundary rules:
- Software CTRL write and hardware EN-clear in the same cycle: the software write wins.
- Any CTRL write clears irq_flag, including writing the same value.
- PRESET write while counting updates PRESET only; it takes effect at the next LOAD.
- EN cleared then set again: goes via LOAD, restarting from PRESET (no resume).
- COUNT never wraps below 0.
- MODE change during CNT takes effect at INT.

Decomposition:
- Package tc_pkg:
  - state typedef {IDLE, LOAD, CNT, INT}
  - offset constants OFF_CTRL=2'd0, OFF_PRESET=2'd1, OFF_COUNT=2'd2
  - CTRL bit indices EN_BIT=0, MODE_LSB=1, IM_BIT=3
  - mode codes MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01
- No sub-module: registers, FSM and read mux fit in one module.

Test Plan:
1. Reset: rst_n low mid-count with COUNT=0x20 -> COUNT=0, CTRL=0, irq=0, state IDLE; PRESET reads PRESET_RST.
2. One-shot: PRESET=5, CTRL=0x9 written at E0 -> COUNT reads 5,4,3,2,1,0; irq=1 after E7 and held. CTRL reads 0x8 (EN cleared). Writing CTRL=0x8 -> irq=0 next cycle.
3. Auto-reload: PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0,(LOAD)3…; EN stays 1.
4. Mask and PRESET=0: PRESET=0, CTRL=0x1 -> INT reached after E3 with irq=0 throughout; then write CTRL=0x9 -> fresh run, irq=1 after E3.
5. Pause and restart: PRESET=10, enable, disable when COUNT=6 -> COUNT holds 6 for 4 cycles; re-enable -> COUNT reloads 10.
6. Register map and collisions:
   - Write 0xFFFF_FFFF to CTRL -> reads 0xF.
   - Write to COUNT and to +0xC -> no effect; +0xC reads 0.
   - PRESET write during CNT -> current run unchanged; next reload uses the new value.
   - CTRL write on the INT cycle -> the written value survives.
